// File: rtl/bitstream_pkg.sv
// Shared definitions for the bit-stream source and sink: FSM state
// encoding, default packet length and a length-saturation helper.
package bitstream_pkg;

  localparam int DEFAULT_MAX_LEN = 16;
  localparam int GAP_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Clamp a requested length to the largest packet the source can hold.
  function automatic int sat_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/bit_packet_source_if.sv
// Load/stream bundle between a bit_packet_source and its neighbours.
// Handshake: a beat transfers on a rising edge where o_valid=1 and
// o_ready=1; once o_valid rises it stays high, with outp/o_sop/o_eop
// stable, until the beat transfers, and it never drops mid-packet.
interface bit_packet_source_if #(
  parameter int MAX_LEN = bitstream_pkg::DEFAULT_MAX_LEN
) ();

  localparam int LW = $clog2(MAX_LEN + 1);

  logic               i_load;
  logic [MAX_LEN-1:0] i_data;
  logic [LW-1:0]      i_len;
  logic               o_ready;
  logic               o_busy;
  logic               o_valid;
  logic               o_sop;
  logic               o_eop;
  logic               outp;
  logic               o_pkt_done;
  logic [7:0]         o_pkt_cnt;

  modport master (
    input  i_load, i_data, i_len, o_ready,
    output o_busy, o_valid, o_sop, o_eop, outp, o_pkt_done, o_pkt_cnt
  );

  modport slave (
    output i_load, i_data, i_len, o_ready,
    input  o_busy, o_valid, o_sop, o_eop, outp, o_pkt_done, o_pkt_cnt
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial datapath: captures a word and its length, shifts one
// bit out LSB first on every transfer and flags the first and last beats.
module bit_serializer #(
  parameter int W  = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  input  logic          shift,
  output logic          bit_out,
  output logic          first,
  output logic          last
);

  logic [W-1:0]  shreg;
  logic [LW-1:0] remaining;
  logic          first_q;

  // Load a new word, or advance one bit when the current beat transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      remaining <= '0;
      first_q   <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= load_len;
      first_q   <= 1'b1;
    end else if (shift) begin
      shreg     <= shreg >> 1;
      remaining <= remaining - LW'(1);
      first_q   <= 1'b0;
    end
  end

  assign bit_out = shreg[0];
  assign first   = first_q;
  assign last    = (remaining == LW'(1));

endmodule

// File: rtl/bit_packet_source.sv
// Serial packet source: accepts a word plus length while idle, streams it
// LSB first under valid/ready flow control, then enforces an idle gap.
module bit_packet_source
  import bitstream_pkg::*;
#(
  parameter int MAX_LEN    = DEFAULT_MAX_LEN,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bit_packet_source_if.master  bus,
  output state_t               dbg_state
);

  localparam int LW = $clog2(MAX_LEN + 1);
  // Gap counter counts down to zero, so it starts one below the gap length.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cnt_q;
  logic [GAP_W-1:0] gap_q;

  logic          accept;
  logic          xfer;
  logic          eop_xfer;
  logic [LW-1:0] eff_len;
  logic          ser_bit;
  logic          ser_first;
  logic          ser_last;

  // Loads are only honoured in IDLE and a zero length is not a packet.
  assign accept   = (state == IDLE) && bus.i_load && (bus.i_len != '0);
  assign xfer     = valid_q && bus.o_ready;
  assign eop_xfer = xfer && ser_last;
  assign eff_len  = LW'(sat_len(int'(bus.i_len), MAX_LEN));

  bit_serializer #(
    .W  (MAX_LEN),
    .LW (LW)
  ) u_ser (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .load_data (bus.i_data),
    .load_len  (eff_len),
    .shift     (xfer),
    .bit_out   (ser_bit),
    .first     (ser_first),
    .last      (ser_last)
  );

  // Packet sequencing: IDLE -> SEND -> (GAP) -> IDLE, with registered flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SEND;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (eop_xfer) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + 8'd1;
            if (GAP_CYCLES == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= GAP;
              gap_q <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
          gap_q   <= '0;
        end
      endcase
    end
  end

  // Beat qualifiers are forced low whenever no beat is being offered.
  assign bus.o_valid    = valid_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_sop      = valid_q & ser_first;
  assign bus.o_eop      = valid_q & ser_last;
  assign bus.outp       = valid_q & ser_bit;
  assign bus.o_pkt_done = done_q;
  assign bus.o_pkt_cnt  = cnt_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_bit_packet_source.sv
// Directed bench for bit_packet_source: transaction-level beat scoreboard
// checked every cycle, plus hand-computed expectations per scenario.
module tb_bit_packet_source;
  import bitstream_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int GAP     = 1;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_t dbg_state;

  bit_packet_source_if #(.MAX_LEN(MAX_LEN)) bus ();

  bit_packet_source #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];      // {sop, eop, bit} per expected beat
  logic       cap_q[$];      // outp of each transferred beat
  logic [7:0] model_cnt = '0;
  logic       exp_done = 1'b0;
  logic       in_pkt = 1'b0;
  logic       pv = 1'b0, pr = 1'b0, psop = 1'b0, peop = 1'b0, pbit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Expected beats of a packet straight from the length/LSB-first rules.
  function automatic void push_pkt(input logic [15:0] data, input int len);
    int n;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 0), (i == n - 1), data[i]});
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    if (!reset_n) begin
      chk("reset_outputs",
          {bus.o_valid, bus.o_sop, bus.o_eop, bus.outp, bus.o_busy, bus.o_pkt_done, bus.o_pkt_cnt},
          32'd0);
      exp_q.delete();
      model_cnt = '0;
      exp_done  = 1'b0;
      in_pkt    = 1'b0;
      pv        = 1'b0;
    end else begin
      chk("pkt_done", bus.o_pkt_done, exp_done);
      chk("pkt_cnt", bus.o_pkt_cnt, model_cnt);
      exp_done = 1'b0;
      if (in_pkt) chk("valid_mid_pkt", bus.o_valid, 1);
      if (pv && !pr)
        chk("stall_hold", {bus.o_valid, bus.o_sop, bus.o_eop, bus.outp}, {1'b1, psop, peop, pbit});
      if (!bus.o_valid) begin
        chk("idle_quiet", {bus.o_sop, bus.o_eop, bus.outp}, 0);
      end else if (bus.o_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          chk("beat", {bus.o_sop, bus.o_eop, bus.outp}, e);
          cap_q.push_back(bus.outp);
          if (e[2]) in_pkt = 1'b1;
          if (e[1]) begin
            in_pkt    = 1'b0;
            exp_done  = 1'b1;
            model_cnt = model_cnt + 8'd1;
          end
        end
      end
      pv = bus.o_valid; pr = bus.o_ready;
      psop = bus.o_sop; peop = bus.o_eop; pbit = bus.outp;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit stall, output int n);
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = 0;
    while (!bus.o_pkt_done && n < budget) begin
      bus.o_ready = stall ? pat[n % 4] : 1'b1;
      tick();
      n++;
    end
    bus.o_ready = 1'b1;
    if (!bus.o_pkt_done) fail("wait_done_timeout");
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.o_busy && n < budget) begin
      tick();
      n++;
    end
    if (bus.o_busy) fail("wait_idle_timeout");
  endtask

  function automatic logic [15:0] cap_word();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16 && i < cap_q.size(); i++) w[i] = cap_q[i];
    return w;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          n, idle;
    logic [15:0] spec_bits;
    logic [15:0] d;
    int          len;
    int          seq [16];

    seq = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 16; i++) spec_bits[i] = seq[i][0];

    bus.i_load = 1'b0; bus.i_data = '0; bus.i_len = '0; bus.o_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_state", dbg_state, IDLE);

    // T1: nominal 16-bit packet, load on first edge after reset release
    reset_n = 1'b1;
    cap_q.delete();
    bus.i_load = 1'b1; bus.i_data = 16'hA5C3; bus.i_len = LW'(16);
    push_pkt(16'hA5C3, 16);
    tick();
    bus.i_load = 1'b0;
    chk("t1_first_beat", {bus.o_valid, bus.o_sop, bus.o_eop, bus.outp, bus.o_busy}, 5'b11011);
    wait_done(40, 1'b0, n);
    chk("t1_latency", n, 16);
    chk("t1_beats", cap_q.size(), 16);
    chk("t1_bits", cap_word(), spec_bits);
    chk("t1_cnt", bus.o_pkt_cnt, 1);
    wait_idle(10);

    // T2: same packet with ready 1,0,0,1 and a conflicting load mid-packet
    cap_q.delete();
    bus.i_load = 1'b1; bus.i_data = 16'hA5C3; bus.i_len = LW'(16);
    push_pkt(16'hA5C3, 16);
    tick();
    bus.i_data = 16'h0000; bus.i_len = LW'(3);
    wait_done(100, 1'b1, n);
    bus.i_load = 1'b0;
    chk("t2_beats", cap_q.size(), 16);
    chk("t2_bits", cap_word(), spec_bits);
    chk("t2_cnt", bus.o_pkt_cnt, 2);
    wait_idle(10);

    // T3: single-beat packet
    cap_q.delete();
    bus.i_load = 1'b1; bus.i_data = 16'h0001; bus.i_len = LW'(1);
    push_pkt(16'h0001, 1);
    tick();
    bus.i_load = 1'b0;
    chk("t3_single", {bus.o_valid, bus.o_sop, bus.o_eop, bus.outp}, 4'b1111);
    wait_done(10, 1'b0, n);
    chk("t3_latency", n, 1);
    chk("t3_cnt", bus.o_pkt_cnt, 3);
    wait_idle(10);

    // T4: zero length ignored, oversize length saturates
    bus.i_load = 1'b1; bus.i_data = 16'hFFFF; bus.i_len = '0;
    repeat (3) begin
      tick();
      chk("t4_len0", {bus.o_valid, bus.o_busy}, 2'b00);
    end
    cap_q.delete();
    bus.i_data = 16'h1234; bus.i_len = LW'(20);
    push_pkt(16'h1234, 20);
    tick();
    bus.i_load = 1'b0;
    wait_done(40, 1'b0, n);
    chk("t4_sat_beats", cap_q.size(), 16);
    chk("t4_sat_bits", cap_word(), 16'h1234);
    chk("t4_cnt", bus.o_pkt_cnt, 4);
    wait_idle(10);

    // T5: reset during beat 5 abandons the packet
    bus.i_load = 1'b1; bus.i_data = 16'hFFFF; bus.i_len = LW'(16);
    push_pkt(16'hFFFF, 16);
    tick();
    bus.i_load = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("t5_async_reset",
        {bus.o_valid, bus.o_sop, bus.o_eop, bus.outp, bus.o_busy, bus.o_pkt_done, bus.o_pkt_cnt},
        32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    bus.i_load = 1'b1; bus.i_data = 16'h00F0; bus.i_len = LW'(8);
    push_pkt(16'h00F0, 8);
    tick();
    bus.i_load = 1'b0;
    chk("t5_new_sop", {bus.o_valid, bus.o_sop, bus.outp}, 3'b110);
    chk("t5_cnt_cleared", bus.o_pkt_cnt, 0);
    wait_done(20, 1'b0, n);
    chk("t5_cnt_after", bus.o_pkt_cnt, 1);
    wait_idle(10);

    // T6: 256 back-to-back packets with load held high throughout
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    bus.i_load = 1'b1;
    for (int k = 0; k < 256; k++) begin
      d   = 16'(k * 40503 + 7);
      len = 1 + (k % 20);
      bus.i_data = d; bus.i_len = LW'(len);
      push_pkt(d, len);
      if (k > 0) begin
        n = 0; idle = 0;
        while (!bus.o_valid && n < 8) begin
          tick();
          n++;
          if (!bus.o_valid && !bus.o_busy) idle++;
        end
        chk("t6_gap_cycles", n, GAP + 1);
        chk("t6_idle_cycles", idle, 1);
      end else begin
        tick();
      end
      chk("t6_sop", {bus.o_valid, bus.o_sop}, 2'b11);
      bus.i_data = ~d; bus.i_len = LW'(MAX_LEN);
      wait_done(80, 1'b0, n);
      if (k == 254) chk("t6_cnt_255", bus.o_pkt_cnt, 255);
    end
    bus.i_load = 1'b0;
    chk("t6_cnt_wrap", bus.o_pkt_cnt, 0);
    wait_idle(10);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_packet_source.md
BIT_PACKET_SOURCE -- requirements
Module: bit_packet_source

Interface
REQ-001 Parameter MAX_LEN, default 16, maximum packet length in bits (legal range 1..32).
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles forced after each packet (legal range 0..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_load  input  1  request to start a packet; sampled only while o_busy=0.
REQ-006 i_data  input  MAX_LEN  packet payload, transmitted LSB first.
REQ-007 i_len  input  $clog2(MAX_LEN+1)  packet length in bits.
REQ-008 o_busy  output  1  high from the cycle after an accepted load until the source returns to IDLE.
REQ-009 o_ready  input  1  downstream ready; a beat transfers when o_valid=1 and o_ready=1.
REQ-010 o_valid  output  1  current beat valid.
REQ-011 o_sop  output  1  marks the first beat of a packet.
REQ-012 o_eop  output  1  marks the last beat of a packet.
REQ-013 outp  output  1  serial data bit of the current beat.
REQ-014 o_pkt_done  output  1  one-cycle pulse the cycle after the eop beat transfers.
REQ-015 o_pkt_cnt  output  8  count of completed packets; wraps 255->0.

Function
REQ-016 FSM states: IDLE, SEND, GAP, held in a registered state variable.
REQ-017 IDLE: when i_load=1 and i_len!=0, capture i_data and the effective length and go to SEND; o_valid=1 with o_sop=1 at the next edge (1-cycle latency).
REQ-018 i_load with i_len=0 is ignored and the FSM stays in IDLE.
REQ-019 i_len>MAX_LEN saturates to MAX_LEN.
REQ-020 i_load is ignored in SEND and GAP, with no effect on the captured data.
REQ-021 SEND: o_valid=1 continuously; outp, o_sop and o_eop stay stable until the beat transfers.
REQ-022 o_valid never deasserts mid-packet.
REQ-023 On each transfer the shift register shifts right one bit and the remaining-beat counter decrements.
REQ-024 With o_ready=0 the state, data and counter hold.
REQ-025 o_sop=1 only on beat 1; o_eop=1 only on beat N.
REQ-026 N=1: o_sop and o_eop are both 1 on the single beat.
REQ-027 On the eop transfer: o_valid, o_sop and o_eop go to 0 next cycle, o_pkt_done pulses, and o_pkt_cnt increments.
REQ-028 After the eop transfer the FSM enters GAP, or IDLE directly if GAP_CYCLES=0.
REQ-029 GAP: o_valid=0 and o_busy=1; a counter runs GAP_CYCLES cycles, then the FSM goes to IDLE.
REQ-030 Outside SEND, o_valid=0, o_sop=0, o_eop=0 and outp=0.
REQ-031 Illegal state encoding recovers to IDLE with all outputs at reset values.

Reset
REQ-032 reset_n=0 immediately forces: state IDLE; o_valid, o_sop, o_eop, outp, o_busy and o_pkt_done to 0; o_pkt_cnt to 0; shift register and counters to 0.
REQ-033 Reset mid-packet abandons the packet with no eop and no o_pkt_done.
REQ-034 The first load is accepted on the first edge after reset_n rises.

Structure
REQ-035 Shared package bitstream_pkg holds the state enum (IDLE, SEND, GAP) and the default MAX_LEN constant, shared with the stream sink.
REQ-036 Sub-module bit_serializer (load, shift-on-transfer, remaining-beat counter, first/last flags) is instantiated once; the FSM and gap timer stay in the top level.

Verification
REQ-037 Load i_data=16'hA5C3, i_len=16, o_ready=1 -> 16 beats on consecutive cycles, outp=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, sop on beat 1, eop on beat 16, o_pkt_done the next cycle, o_pkt_cnt=1.
REQ-038 Same packet with o_ready toggling 1,0,0,1 -> outputs stable while stalled; bit sequence identical; 16 transfers total.
REQ-039 i_len=1, i_data[0]=1 -> single beat with o_sop=o_eop=outp=1.
REQ-040 i_len=0 -> no o_valid and o_busy stays 0; i_len=20 -> 16 beats.
REQ-041 reset_n=0 at beat 5 -> all outputs 0 within the same cycle; a new load after release starts with sop; o_pkt_cnt=0.
REQ-042 256 back-to-back packets, GAP_CYCLES=1 -> exactly one idle cycle between eop and the next sop; o_pkt_cnt wraps to 0; loads during SEND ignored.
